// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants, also used by the image reader stage
package vga_pkg;
    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;
    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_CLK_DIV   = 4;
    localparam int IMG_W         = 320;
    localparam int IMG_H         = 240;
    typedef logic [9:0] coord_t;
endpackage

// File: rtl/pixel_tick_gen.sv
// pixel_tick_gen: divides clk by CLK_DIV, tick high in the last clk of each pixel period
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    always_comb begin
        tick      = div_cnt_q == DW'(CLK_DIV - 1);
        div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) div_cnt_q <= '0;
        else       div_cnt_q <= div_cnt_d;
    end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel/line counters with registered sync, display-enable and position decode
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FP      = VGA_H_FP,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BP      = VGA_H_BP,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FP      = VGA_V_FP,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BP      = VGA_V_BP,
    parameter int CLK_DIV   = VGA_CLK_DIV
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pixel_tick,
    output logic       h_sync,
    output logic       v_sync,
    output logic       DE,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    logic tick, h_end, v_end;
    coord_t h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, x_q, x_d, y_q, y_d;
    logic wrap_q, wrap_d, de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
    pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );
    always_comb begin
        h_end   = h_cnt_q == 10'(H_TOTAL - 1);
        v_end   = v_cnt_q == 10'(V_TOTAL - 1);
        h_cnt_d = !tick ? h_cnt_q : h_end ? '0 : h_cnt_q + 10'd1;
        v_cnt_d = !(tick && h_end) ? v_cnt_q : v_end ? '0 : v_cnt_q + 10'd1;
        wrap_d  = tick && h_end && v_end;
        de_d    = h_cnt_q < 10'(H_VISIBLE) && v_cnt_q < 10'(V_VISIBLE);
        hs_d    = !(h_cnt_q >= 10'(H_VISIBLE + H_FP) && h_cnt_q < 10'(H_VISIBLE + H_FP + H_SYNC));
        vs_d    = !(v_cnt_q >= 10'(V_VISIBLE + V_FP) && v_cnt_q < 10'(V_VISIBLE + V_FP + V_SYNC));
        x_d     = h_cnt_q;
        y_d     = v_cnt_q;
        // wrap_q marks the counters now sitting on the freshly wrapped (0,0)
        fs_d    = wrap_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            wrap_q  <= 1'b0;
            de_q    <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            x_q     <= '0;
            y_q     <= '0;
            fs_q    <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            wrap_q  <= wrap_d;
            de_q    <= de_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fs_q    <= fs_d;
        end
    end
    assign pixel_tick  = tick;
    assign DE          = de_q;
    assign h_sync      = hs_q;
    assign v_sync      = vs_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scaled-down timing checked against an arithmetic pixel-index model
module tb_vga_sync_gen;
    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 4, VF = 1, VS = 2, VB = 1;
    localparam int CD = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME_CLKS = HT * VT * CD;

    logic clk = 1'b0, reset = 1'b0;
    logic pixel_tick, h_sync, v_sync, DE, frame_start;
    logic [9:0] x, y;
    int total = 0, bad = 0;
    int k = 0;
    bit in_rst = 1'b0;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CLK_DIV(CD)
    ) dut (
        .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .h_sync(h_sync),
        .v_sync(v_sync), .DE(DE), .x(x), .y(y), .frame_start(frame_start)
    );

    typedef struct {
        int   k;
        logic tick;
        int   x;
        int   y;
        logic de;
        logic hs;
        logic vs;
    } vec_t;
    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (k=%0d)", name, act, exp, k);
        end
    endtask

    function automatic logic [24:0] dut_vec();
        return {pixel_tick, h_sync, v_sync, DE, frame_start, x, y};
    endfunction

    // outputs after edge k show pixel index P=(k-1)/CD of the free-running raster
    function automatic logic [24:0] model_vec();
        int p, ex, ey;
        logic t, de, hs, vs, fs;
        if (in_rst || k == 0) return {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0};
        p  = (k - 1) / CD;
        ex = p % HT;
        ey = (p / HT) % VT;
        t  = (k % CD) == CD - 1;
        de = ex < HV && ey < VV;
        hs = !(ex >= HV + HF && ex < HV + HF + HS);
        vs = !(ey >= VV + VF && ey < VV + VF + VS);
        fs = p > 0 && p % (HT * VT) == 0 && (k - 1) % CD == 0;
        return {t, hs, vs, de, fs, 10'(ex), 10'(ey)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (!in_rst) k++;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset  = 1'b0;
        in_rst = 1'b0;
        k      = 0;
        check("post_release", 32'(dut_vec()), 32'(model_vec()));
    endtask

    int fs_count, last_fs;

    initial begin
        tbl[0]  = '{1,   1'b0, 0,  0, 1'b1, 1'b1, 1'b1};
        tbl[1]  = '{3,   1'b1, 0,  0, 1'b1, 1'b1, 1'b1};
        tbl[2]  = '{5,   1'b0, 1,  0, 1'b1, 1'b1, 1'b1};
        tbl[3]  = '{7,   1'b1, 1,  0, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{32,  1'b0, 7,  0, 1'b1, 1'b1, 1'b1};
        tbl[5]  = '{33,  1'b0, 8,  0, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{40,  1'b0, 9,  0, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{41,  1'b0, 10, 0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{52,  1'b0, 12, 0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{53,  1'b0, 13, 0, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{60,  1'b0, 14, 0, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{61,  1'b0, 0,  1, 1'b1, 1'b1, 1'b1};
        tbl[12] = '{300, 1'b0, 14, 4, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{301, 1'b0, 0,  5, 1'b0, 1'b1, 1'b0};

        #1 reset = 1'b1;
        in_rst = 1'b1;
        #1 check("async_reset_initial", 32'(dut_vec()), 32'(model_vec()));
        step();
        step();
        release_reset();

        foreach (tbl[i]) begin
            while (k < tbl[i].k) step();
            check($sformatf("tbl%0d", i), {25'd0, tbl[i].tick, tbl[i].de, tbl[i].hs, tbl[i].vs, 10'(tbl[i].x), 10'(tbl[i].y)},
                  {25'd0, pixel_tick, DE, h_sync, v_sync, x, y});
        end

        reset  = 1'b1;
        in_rst = 1'b1;
        #1 check("async_reset_mid", 32'(dut_vec()), 32'(model_vec()));
        step();
        release_reset();
        fs_count = 0;
        last_fs  = 0;
        for (int n = 0; n < 3 * FRAME_CLKS + 1; n++) begin
            step();
            check("run", 32'(dut_vec()), 32'(model_vec()));
            if (frame_start === 1'b1) begin
                if (fs_count > 0) check("frame_len", 32'(k - last_fs), 32'(FRAME_CLKS));
                else check("first_frame_len", 32'(k), 32'(FRAME_CLKS + 1));
                fs_count++;
                last_fs = k;
            end
            if (DE === 1'b1 && x < 10'(HV / 2) && y < 10'(VV / 2))
                check("img_addr", 32'((32'(y) * (HV / 2) + 32'(x)) < (HV / 2) * (VV / 2)), 32'd1);
        end
        check("frame_start_count", 32'(fs_count), 32'd3);

        for (int r = 0; r < 6; r++) begin
            for (int n = $urandom_range(5, 1500); n > 0; n--) begin
                step();
                check("rand_run", 32'(dut_vec()), 32'(model_vec()));
            end
            #($urandom_range(1, 3));
            reset  = 1'b1;
            in_rst = 1'b1;
            #1 check("async_reset_rand", 32'(dut_vec()), 32'(model_vec()));
            for (int c = 0; c < 3; c++) begin
                step();
                check("held_reset", 32'(dut_vec()), 32'(model_vec()));
            end
            release_reset();
            for (int n = 0; n < 16; n++) begin
                step();
                check("restart", 32'(dut_vec()), 32'(model_vec()));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal porch and sync widths in pixels.
REQ-003 Parameter V_VISIBLE, default 480, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 Parameter CLK_DIV, default 4, system clocks per pixel.
REQ-006 clk  input  1  system clock (100 MHz); the only clock in the block.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 pixel_tick  output  1  one-clk pulse marking each pixel period.
REQ-009 h_sync  output  1  horizontal sync, active low.
REQ-010 v_sync  output  1  vertical sync, active low.
REQ-011 DE  output  1  display enable, high inside the visible area.
REQ-012 x  output  10  current column, 0..H_TOTAL-1.
REQ-013 y  output  10  current line, 0..V_TOTAL-1.
REQ-014 frame_start  output  1  one-clk pulse when position (0,0) is presented.

Function
REQ-015 H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
REQ-016 div_cnt counts 0..CLK_DIV-1 every clk and wraps; tick = (div_cnt == CLK_DIV-1).
REQ-017 pixel_tick = tick, registered-source decode, no extra latency.
REQ-018 h_cnt increments on clk when tick; at H_TOTAL-1 wraps to 0.
REQ-019 v_cnt increments only when tick and h_cnt == H_TOTAL-1; at V_TOTAL-1 wraps to 0 simultaneously with h_cnt wrap.
REQ-020 DE, h_sync, v_sync, x, y, frame_start registered one clk after the counter values they decode; decode updated every clk.
REQ-021 DE = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
REQ-022 h_sync low iff H_VISIBLE+H_FP <= h_cnt < H_VISIBLE+H_FP+H_SYNC (656..751).
REQ-023 v_sync low iff V_VISIBLE+V_FP <= v_cnt < V_VISIBLE+V_FP+V_SYNC (490..491).
REQ-024 x = h_cnt, y = v_cnt, unconditionally; downstream gates with DE.
REQ-025 frame_start high for exactly one clk, on the clk the registered outputs first show x=0,y=0 after a v_cnt wrap; not asserted for the post-reset (0,0).
REQ-026 All widths 10 bits; counters never exceed TOTAL-1; no overflow path.

Reset
REQ-027 reset asserted: div_cnt=0, h_cnt=0, v_cnt=0 immediately, independent of clk.
REQ-028 Output reset values: pixel_tick=0, DE=0, h_sync=1, v_sync=1, x=0, y=0, frame_start=0.
REQ-029 Reset mid-frame aborts the frame; after release timing restarts from (0,0), first tick on the CLK_DIV-th rising edge.

Structure
REQ-030 Shared package vga_pkg holds the timing constants (visible, porch, sync, totals) and CLK_DIV default; also used by the image reader stage.
REQ-031 One sub-module, pixel_tick_gen (div_cnt and tick), instantiated once; counters and decode in the top.

Verification
REQ-032 Release reset, run 12 clks -> pixel_tick high on clks 4, 8, 12 only; x=0,y=0, DE=1 after first decode.
REQ-033 Run one line -> DE high for 640 ticks, h_sync low for exactly 96 ticks starting x=656, line length 3200 clks.
REQ-034 Run one frame -> v_sync low for lines 490..491 (2 x 3200 clks), DE low for y>=480, frame length 1,680,000 clks.
REQ-035 At x=799,y=524 plus one tick -> x=0,y=0 and frame_start single-clk pulse; none at the post-reset (0,0).
REQ-036 Assert reset at x=300,y=200 for 3 clks -> outputs at reset values asynchronously; after release, sequence matches REQ-032.
REQ-037 Cross-check with image reader: addr=320*y+x stays within 0..76799 whenever DE && x<320 && y<240.
